// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state encodings and port ids shared by the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant select; round-robin on ties when MEM_ARB_RR_EN is defined
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic       gnt
);
`ifdef MEM_ARB_RR_EN
  assign gnt = &req ? ~last_grant : (req == 2'b10 ? PORT1 : PORT0);
`else
  assign gnt = req == 2'b10 ? PORT1 : PORT0;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port single-memory arbiter with wait states; MEM_ARB_RR_EN enables round-robin
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 30,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          grant, grant_nx, pick, busy, start;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [31:0]   g_wdata;
  logic [3:0]    g_wstrb;
  assign start = state == IDLE && (m0_req || m1_req);
`ifdef MEM_ARB_RR_EN
  logic last_grant;
  always_ff @(posedge clk)
    if (!rstn) last_grant <= PORT1;
    else if (start) last_grant <= pick;
  mem_arb_pick u_pick (.req({m1_req, m0_req}), .last_grant(last_grant), .gnt(pick));
`else
  mem_arb_pick u_pick (.req({m1_req, m0_req}), .gnt(pick));
`endif
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      cnt   <= 4'd0;
      grant <= PORT0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      grant <= grant_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant_nx = grant;
    unique case (state)
      IDLE: if (start) begin
        state_nx = ACCESS;
        cnt_nx   = 4'(WAIT_CYCLES);
        grant_nx = pick;
      end
      ACCESS: if (cnt == 4'd0) state_nx = RESP;
              else cnt_nx = cnt - 4'd1;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign g_we    = grant ? m1_we    : m0_we;
  assign g_addr  = grant ? m1_addr  : m0_addr;
  assign g_wdata = grant ? m1_wdata : m0_wdata;
  assign g_wstrb = grant ? m1_wstrb : m0_wstrb;
  assign busy      = state != IDLE;
  // rstn gates the strobes directly so a write never issues while reset is low
  assign mem_en    = rstn && busy;
  assign mem_we    = (rstn && state == ACCESS && cnt == 4'd0 && g_we) ? g_wstrb : 4'b0;
  assign mem_addr  = busy ? g_addr : '0;
  assign mem_wdata = busy ? g_wdata : '0;
  assign m0_ready  = rstn && state == RESP && grant == PORT0;
  assign m1_ready  = rstn && state == RESP && grant == PORT1;
  assign m0_rdata  = (busy && grant == PORT0) ? mem_rdata : '0;
  assign m1_rdata  = (busy && grant == PORT1) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (WAIT_CYCLES 1, plus 0 and 3)
module tb_mem_arbiter;
  logic        clk, rstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready, mem_en;
  logic [31:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic [7:0]  mem_addr;
  logic        w0_m0_ready, w0_m1_ready, w0_mem_en, w3_m0_ready, w3_m1_ready, w3_mem_en;
  logic [31:0] w0_m0_rdata, w0_m1_rdata, w0_mem_wdata, w0_mem_rdata;
  logic [31:0] w3_m0_rdata, w3_m1_rdata, w3_mem_wdata, w3_mem_rdata;
  logic [3:0]  w0_mem_we, w3_mem_we;
  logic [7:0]  w0_mem_addr, w3_mem_addr;
  logic [31:0] mem [0:255];
  logic        bd_en;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;
  int          vecs = 0, errs = 0, we_cnt = 0;
  mem_arbiter #(.AW(8), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  mem_arbiter #(.AW(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(w0_m0_ready), .m0_rdata(w0_m0_rdata),
    .m1_req(1'b0), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(w0_m1_ready), .m1_rdata(w0_m1_rdata),
    .mem_en(w0_mem_en), .mem_we(w0_mem_we), .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata),
    .mem_rdata(w0_mem_rdata));
  mem_arbiter #(.AW(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(w3_m0_ready), .m0_rdata(w3_m0_rdata),
    .m1_req(1'b0), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(w3_m1_ready), .m1_rdata(w3_m1_rdata),
    .mem_en(w3_mem_en), .mem_we(w3_mem_we), .mem_addr(w3_mem_addr), .mem_wdata(w3_mem_wdata),
    .mem_rdata(w3_mem_rdata));
  assign mem_rdata    = mem[mem_addr];
  assign w0_mem_rdata = mem[w0_mem_addr];
  assign w3_mem_rdata = mem[w3_mem_addr];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else for (int i = 0; i < 4; i++) if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_we != 4'b0) we_cnt <= we_cnt + 1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_en = 1'b0;
  endtask
  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    m0_req = 1'b1;
    tick();
    tick();
    vecs++; if ({mem_en, mem_we} !== 5'b0) begin errs++; $display("FAIL reset_mem_ctl: got %b want 00000", {mem_en, mem_we}); end
    vecs++; if ({m0_ready, m1_ready} !== 2'b0) begin errs++; $display("FAIL reset_ready: got %b want 00", {m0_ready, m1_ready}); end
    vecs++; if ({m0_rdata, m1_rdata} !== 64'b0) begin errs++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
    vecs++; if ({mem_addr, mem_wdata} !== 40'b0) begin errs++; $display("FAIL reset_addr_wdata: got %h want 0", {mem_addr, mem_wdata}); end
    m0_req = 1'b0;
    rstn = 1'b1;
    tick();
  endtask
  task automatic test_read();
    int lat = 0;
    logic [31:0] rd = 0;
    logic other = 0;
    poke(8'h10, 32'hDEADBEEF);
    m0_addr = 8'h10; m0_we = 0; m0_req = 1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick();
      if (m1_ready || m1_rdata !== 32'h0) other = 1;
      if (m0_ready) begin lat = c; rd = m0_rdata; end
    end
    m0_req = 0;
    tick();
    vecs++; if (lat !== 3) begin errs++; $display("FAIL read_latency: got %0d want 3", lat); end
    vecs++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL read_data: got %h want deadbeef", rd); end
    vecs++; if (other !== 1'b0) begin errs++; $display("FAIL read_other_port_quiet: got %b want 0", other); end
  endtask
  task automatic test_write();
    int lat = 0, w0 = we_cnt;
    logic other = 0;
    poke(8'h04, 32'hAABBCCDD);
    w0 = we_cnt;
    m1_addr = 8'h04; m1_we = 1; m1_wdata = 32'h11223344; m1_wstrb = 4'b0101; m1_req = 1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick();
      if (m0_ready) other = 1;
      if (m1_ready) lat = c;
    end
    m1_req = 0;
    tick();
    tick();
    vecs++; if (lat !== 3) begin errs++; $display("FAIL write_latency: got %0d want 3", lat); end
    vecs++; if (mem[8'h04] !== 32'hAA22CC44) begin errs++; $display("FAIL write_bytes: got %h want aa22cc44", mem[8'h04]); end
    vecs++; if (we_cnt - w0 !== 1) begin errs++; $display("FAIL write_single_we: got %0d want 1", we_cnt - w0); end
    vecs++; if (other !== 1'b0) begin errs++; $display("FAIL write_m0_quiet: got %b want 0", other); end
    m1_we = 0; m1_wstrb = 0;
  endtask
  task automatic test_zero_strb();
    int lat = 0, w0 = 0;
    poke(8'h05, 32'h12345678);
    w0 = we_cnt;
    m0_addr = 8'h05; m0_we = 1; m0_wdata = 32'hFFFFFFFF; m0_wstrb = 4'b0000; m0_req = 1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick();
      if (m0_ready) lat = c;
    end
    m0_req = 0;
    tick();
    tick();
    vecs++; if (lat !== 3) begin errs++; $display("FAIL zstrb_latency: got %0d want 3", lat); end
    vecs++; if (mem[8'h05] !== 32'h12345678 || we_cnt != w0) begin
      errs++; $display("FAIL zstrb_no_write: got %h/%0d want 12345678/0", mem[8'h05], we_cnt - w0); end
    m0_we = 0; m0_wdata = 0;
  endtask
  task automatic test_tie();
    int n = 0;
    int seq [4];
    int t [4];
    int exp_seq [4];
    logic both = 0;
`ifdef MEM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    do_reset();
    m0_addr = 8'h10; m1_addr = 8'h04; m0_req = 1; m1_req = 1;
    for (int c = 1; c <= 80 && n < 4; c++) begin
      tick();
      if (m0_ready && m1_ready) both = 1;
      if (m0_ready) begin seq[n] = 0; t[n] = c; n++; end
      else if (m1_ready) begin seq[n] = 1; t[n] = c; n++; end
    end
    m0_req = 0; m1_req = 0;
    tick();
    tick();
    vecs++; if (n !== 4) begin errs++; $display("FAIL tie_count: got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (seq[i] !== exp_seq[i]) begin errs++; $display("FAIL tie_order[%0d]: got port %0d want port %0d", i, seq[i], exp_seq[i]); end
    end
    vecs++; if (t[1] - t[0] !== 4) begin errs++; $display("FAIL tie_throughput: got %0d want 4", t[1] - t[0]); end
    vecs++; if (both !== 1'b0) begin errs++; $display("FAIL tie_both_ready: got %b want 0", both); end
  endtask
  task automatic test_back_to_back();
    int n = 0, left = 3;
    int seq [4];
    int exp_seq [4];
    logic both = 0;
    logic [31:0] r1 = 0;
`ifdef MEM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 0};
`else
    exp_seq = '{0, 0, 0, 1};
`endif
    do_reset();
    m0_addr = 8'h10; m1_addr = 8'h04; m0_req = 1; m1_req = 1;
    for (int c = 1; c <= 80 && n < 4; c++) begin
      tick();
      if (m0_ready && m1_ready) both = 1;
      if (m0_ready) begin seq[n] = 0; n++; left--; if (left == 0) m0_req = 0; end
      if (m1_ready) begin seq[n] = 1; n++; r1 = m1_rdata; m1_req = 0; end
    end
    m0_req = 0; m1_req = 0;
    tick();
    vecs++; if (n !== 4) begin errs++; $display("FAIL b2b_count: got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (seq[i] !== exp_seq[i]) begin errs++; $display("FAIL b2b_order[%0d]: got port %0d want port %0d", i, seq[i], exp_seq[i]); end
    end
    vecs++; if (both !== 1'b0) begin errs++; $display("FAIL b2b_both_ready: got %b want 0", both); end
    vecs++; if (r1 !== 32'hAA22CC44) begin errs++; $display("FAIL b2b_m1_rdata: got %h want aa22cc44", r1); end
  endtask
  task automatic test_latency();
    int l0 = 0, l3 = 0;
    logic [31:0] r0 = 0, r3 = 0;
    logic addr_bad = 0, extra_bad = 0;
    do_reset();
    m0_addr = 8'h10; m0_we = 0; m0_wdata = 0; m0_req = 1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if ((w0_mem_en && w0_mem_addr !== 8'h10) || (w3_mem_en && w3_mem_addr !== 8'h10)) addr_bad = 1;
      if (w0_mem_we != 0 || w3_mem_we != 0 || w0_m1_ready || w3_m1_ready) extra_bad = 1;
      if (w0_m1_rdata != 0 || w3_m1_rdata != 0 || w0_mem_wdata != 0 || w3_mem_wdata != 0) extra_bad = 1;
      if (l0 == 0 && w0_m0_ready) begin l0 = c; r0 = w0_m0_rdata; end
      if (l3 == 0 && w3_m0_ready) begin l3 = c; r3 = w3_m0_rdata; m0_req = 0; end
    end
    vecs++; if (l0 !== 2) begin errs++; $display("FAIL wait0_latency: got %0d want 2", l0); end
    vecs++; if (l3 !== 5) begin errs++; $display("FAIL wait3_latency: got %0d want 5", l3); end
    vecs++; if (r0 !== 32'hDEADBEEF || r3 !== 32'hDEADBEEF) begin
      errs++; $display("FAIL wait_rdata: got %h/%h want deadbeef", r0, r3); end
    vecs++; if (addr_bad !== 1'b0) begin errs++; $display("FAIL wait_addr_stable: got %b want 0", addr_bad); end
    vecs++; if (extra_bad !== 1'b0) begin errs++; $display("FAIL wait_quiet_outputs: got %b want 0", extra_bad); end
  endtask
  task automatic test_reset_abort();
    int w0 = 0, lat = 0;
    logic rdy = 0;
    do_reset();
    poke(8'h08, 32'h0);
    w0 = we_cnt;
    m0_addr = 8'h08; m0_we = 1; m0_wdata = 32'hFFFFFFFF; m0_wstrb = 4'hF; m0_req = 1;
    tick();
    tick();
    vecs++; if (mem_we !== 4'hF) begin errs++; $display("FAIL abort_pre_we: got %b want 1111", mem_we); end
    rstn = 1'b0;
    #1;
    vecs++; if ({mem_en, mem_we} !== 5'b0) begin errs++; $display("FAIL abort_gated: got %b want 00000", {mem_en, mem_we}); end
    m0_req = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (m0_ready || m1_ready) rdy = 1;
    end
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (m0_ready || m1_ready) rdy = 1;
    end
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL abort_no_ready: got %b want 0", rdy); end
    vecs++; if (mem[8'h08] !== 32'h0 || we_cnt != w0) begin
      errs++; $display("FAIL abort_no_write: got %h/%0d want 0/0", mem[8'h08], we_cnt - w0); end
    m0_addr = 8'h10; m0_we = 0; m0_wdata = 0; m0_wstrb = 0; m0_req = 1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick();
      if (m0_ready) lat = c;
    end
    m0_req = 0;
    tick();
    vecs++; if (lat !== 3) begin errs++; $display("FAIL abort_next_latency: got %0d want 3", lat); end
  endtask
  initial begin
    rstn = 1'b0;
    bd_en = 1'b0; bd_addr = 0; bd_data = 0;
    idle_inputs();
    tick();
    test_reset();
    test_read();
    test_write();
    test_zero_strb();
    test_tie();
    test_back_to_back();
    test_latency();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
